// File: rtl/nram_regfile_2r1w.sv
// DEPTH x WIDTH register file with one write port and two independent read ports.
// Reads are registered (with optional write/clear forwarding) or combinational, selected by parameter.
module nram_regfile_2r1w #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 2,
    parameter int READ_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    clr,
    input  logic                    rd_en_a,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    output logic [WIDTH-1:0]        rd_data_a,
    output logic                    rd_valid_a,
    input  logic                    rd_en_b,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    output logic [WIDTH-1:0]        rd_data_b,
    output logic                    rd_valid_b,
    output logic [(1<<ADDR_W)-1:0]  entry_vld
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  vld_d;

    logic              rd_en   [2];
    logic [ADDR_W-1:0] rd_addr [2];
    logic [WIDTH-1:0]  rd_data [2];
    logic              rd_valid[2];

    // Clear wins over a simultaneous write; the write is dropped.
    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            vld_d = '0;
        end else if (wr_en) begin
            mem_d[wr_addr] = wr_data;
            vld_d[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            vld_q <= vld_d;
        end
    end

    assign entry_vld = vld_q;

    assign rd_en[0]   = rd_en_a;
    assign rd_addr[0] = rd_addr_a;
    assign rd_en[1]   = rd_en_b;
    assign rd_addr[1] = rd_addr_b;

    assign rd_data_a  = rd_data[0];
    assign rd_valid_a = rd_valid[0];
    assign rd_data_b  = rd_data[1];
    assign rd_valid_b = rd_valid[1];

    for (genvar p = 0; p < 2; p++) begin : g_port
        if (READ_REG != 0) begin : g_reg
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;
            logic             valid_q;
            logic             valid_d;

            // Forwarding reads the post-edge image, which already folds in write and clear.
            always_comb begin
                data_d  = data_q;
                valid_d = rd_en[p];
                if (rd_en[p]) begin
                    data_d = (BYPASS != 0) ? mem_d[rd_addr[p]] : mem_q[rd_addr[p]];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign rd_data[p]  = data_q;
            assign rd_valid[p] = valid_q;
        end else begin : g_comb
            assign rd_data[p]  = mem_q[rd_addr[p]];
            assign rd_valid[p] = rd_en[p];
        end
    end

endmodule
